// File: rtl/decode_pipe_if.sv
// Handshake, write-back and decoded-bundle signals of the decode stage.
// The slave modport is the decode stage itself; master is whoever drives it.
interface decode_pipe_if #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
);
  localparam int AW = $clog2(NUM_REGS);

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic            flush;
  logic            wb_en;
  logic [AW-1:0]   wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_op1;
  logic [XLEN-1:0] out_op2;
  logic [XLEN-1:0] out_imm;
  logic [AW-1:0]   out_rd;
  logic [3:0]      out_alu_ctl;
  logic            out_reg_wr;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_instr, flush, wb_en, wb_addr, wb_data, out_ready,
    output in_ready, out_valid, out_op1, out_op2, out_imm, out_rd,
           out_alu_ctl, out_reg_wr, out_illegal
  );

  modport master (
    output in_valid, in_instr, flush, wb_en, wb_addr, wb_data, out_ready,
    input  in_ready, out_valid, out_op1, out_op2, out_imm, out_rd,
           out_alu_ctl, out_reg_wr, out_illegal
  );
endinterface

// File: rtl/decode_pipe.sv
// Registered decode stage: register file with write-back bypass, R/I/J decode,
// and a single output slot under a valid/ready handshake with flush.
module decode_pipe #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter bit IMM_SEXT = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  decode_pipe_if.slave  bus
);
  localparam int AW = $clog2(NUM_REGS);

  logic [XLEN-1:0] regs_q [NUM_REGS];

  logic [5:0]      opcode;
  logic [AW-1:0]   rsAddr, rtAddr, rdAddr;
  logic [15:0]     imm16;
  logic [XLEN-1:0] immExt;
  logic [XLEN-1:0] op1_d, op2_d, imm_d;
  logic [AW-1:0]   rd_d;
  logic [3:0]      alu_d;
  logic            regWr_d, illegal_d;

  logic            valid_q, valid_d;
  logic [XLEN-1:0] op1_q, op2_q, imm_q;
  logic [AW-1:0]   rd_q;
  logic [3:0]      alu_q;
  logic            regWr_q, illegal_q;
  logic            capture;

  assign opcode = bus.in_instr[31:26];
  assign rsAddr = bus.in_instr[21 +: AW];
  assign rtAddr = bus.in_instr[16 +: AW];
  assign rdAddr = bus.in_instr[11 +: AW];
  assign imm16  = bus.in_instr[15:0];
  assign immExt = IMM_SEXT ? {{(XLEN-16){imm16[15]}}, imm16}
                           : {{(XLEN-16){1'b0}}, imm16};

  // Register 0 is hard-wired; a same-cycle write-back wins over the stored value.
  assign op1_d = (rsAddr == '0) ? '0 :
                 (bus.wb_en && bus.wb_addr == rsAddr) ? bus.wb_data : regs_q[rsAddr];
  assign op2_d = (rtAddr == '0) ? '0 :
                 (bus.wb_en && bus.wb_addr == rtAddr) ? bus.wb_data : regs_q[rtAddr];

  always_comb begin
    alu_d     = 4'b0000;
    rd_d      = '0;
    regWr_d   = 1'b0;
    illegal_d = 1'b0;
    imm_d     = '0;
    case (opcode)
      6'b000000: begin
        alu_d   = 4'b0001;
        rd_d    = rdAddr;
        regWr_d = 1'b1;
      end
      6'b000001: begin
        alu_d   = 4'b0010;
        rd_d    = rtAddr;
        regWr_d = 1'b1;
        imm_d   = immExt;
      end
      6'b000010: ;
      default:   illegal_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (bus.wb_en && bus.wb_addr != '0) begin
      regs_q[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Flush beats capture and also drops whatever bundle is currently held.
  assign bus.in_ready = !valid_q || bus.out_ready;
  assign capture      = bus.in_valid && bus.in_ready && !bus.flush;
  assign valid_d      = bus.flush ? 1'b0 :
                        capture   ? 1'b1 :
                        bus.out_ready ? 1'b0 : valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      op1_q     <= '0;
      op2_q     <= '0;
      imm_q     <= '0;
      rd_q      <= '0;
      alu_q     <= '0;
      regWr_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (capture) begin
        op1_q     <= op1_d;
        op2_q     <= op2_d;
        imm_q     <= imm_d;
        rd_q      <= rd_d;
        alu_q     <= alu_d;
        regWr_q   <= regWr_d;
        illegal_q <= illegal_d;
      end
    end
  end

  assign bus.out_valid   = valid_q;
  assign bus.out_op1     = op1_q;
  assign bus.out_op2     = op2_q;
  assign bus.out_imm     = imm_q;
  assign bus.out_rd      = rd_q;
  assign bus.out_alu_ctl = alu_q;
  assign bus.out_reg_wr  = regWr_q;
  assign bus.out_illegal = illegal_q;
endmodule

// File: tb/tb_decode_pipe.sv
// Directed bench for decode_pipe: table of single-instruction vectors plus
// hand-written handshake, bypass, flush and reset sequences.
module tb_decode_pipe;
  logic clk = 1'b0;
  logic rst_n;
  int   testsRun = 0;
  int   failCount = 0;

  always #5 clk = ~clk;

  decode_pipe_if #(.XLEN(32), .NUM_REGS(32)) busA ();
  decode_pipe_if #(.XLEN(32), .NUM_REGS(32)) busB ();

  decode_pipe #(.XLEN(32), .NUM_REGS(32), .IMM_SEXT(1'b1)) dutSext (
    .clk(clk), .rst_n(rst_n), .bus(busA.slave));
  decode_pipe #(.XLEN(32), .NUM_REGS(32), .IMM_SEXT(1'b0)) dutZext (
    .clk(clk), .rst_n(rst_n), .bus(busB.slave));

  assign busB.in_valid  = busA.in_valid;
  assign busB.in_instr  = busA.in_instr;
  assign busB.flush     = busA.flush;
  assign busB.wb_en     = busA.wb_en;
  assign busB.wb_addr   = busA.wb_addr;
  assign busB.wb_data   = busA.wb_data;
  assign busB.out_ready = busA.out_ready;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] op1, op2, imm, immZ;
    logic [4:0]  rd;
    logic [3:0]  alu;
    logic        regWr, illegal, chkImm;
  } vec_t;

  vec_t vecs[6];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] instr);
    @(negedge clk);
    busA.in_valid = 1'b1;
    busA.in_instr = instr;
    @(negedge clk);
    busA.in_valid = 1'b0;
  endtask

  task automatic writeReg(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    busA.wb_en   = 1'b1;
    busA.wb_addr = addr;
    busA.wb_data = data;
    @(negedge clk);
    busA.wb_en   = 1'b0;
  endtask

  function automatic logic [31:0] rType(input logic [4:0] rs, rt, rd);
    return {6'd0, rs, rt, rd, 11'd0};
  endfunction

  initial begin
    vecs[0] = '{"r_add",   rType(5'd1, 5'd2, 5'd3),   32'h11, 32'h22, 32'h0, 32'h0, 5'd3, 4'b0001, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{"addi_neg", {6'd1, 5'd1, 5'd5, 16'hFFFE}, 32'h11, 32'h0, 32'hFFFF_FFFE, 32'h0000_FFFE, 5'd5, 4'b0010, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{"addi_pos", {6'd1, 5'd2, 5'd7, 16'h1234}, 32'h22, 32'hDEAD_BEEF, 32'h1234, 32'h1234, 5'd7, 4'b0010, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{"j_type",  {6'd2, 5'd1, 5'd2, 16'h0},  32'h11, 32'h22, 32'h0, 32'h0, 5'd0, 4'b0000, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{"illegal", {6'h3F, 5'd2, 5'd1, 16'hFFFF}, 32'h22, 32'h11, 32'h0, 32'h0, 5'd0, 4'b0000, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{"r_zero",  rType(5'd0, 5'd0, 5'd31), 32'h0, 32'h0, 32'h0, 32'h0, 5'd31, 4'b0001, 1'b1, 1'b0, 1'b1};

    rst_n          = 1'b0;
    busA.in_valid  = 1'b0;
    busA.in_instr  = '0;
    busA.flush     = 1'b0;
    busA.wb_en     = 1'b0;
    busA.wb_addr   = '0;
    busA.wb_data   = '0;
    busA.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_valid", busA.out_valid, 0);
    checkOutput("reset_ready", busA.in_ready, 1);
    checkOutput("reset_op1", busA.out_op1, 0);
    checkOutput("reset_rd", busA.out_rd, 0);
    checkOutput("reset_alu", busA.out_alu_ctl, 0);

    writeReg(5'd1, 32'h11);
    writeReg(5'd2, 32'h22);
    writeReg(5'd7, 32'hDEAD_BEEF);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].instr);
      checkOutput({vecs[i].name, "_valid"}, busA.out_valid, 1);
      checkOutput({vecs[i].name, "_op1"}, busA.out_op1, vecs[i].op1);
      checkOutput({vecs[i].name, "_op2"}, busA.out_op2, vecs[i].op2);
      checkOutput({vecs[i].name, "_rd"}, busA.out_rd, vecs[i].rd);
      checkOutput({vecs[i].name, "_alu"}, busA.out_alu_ctl, vecs[i].alu);
      checkOutput({vecs[i].name, "_regwr"}, busA.out_reg_wr, vecs[i].regWr);
      checkOutput({vecs[i].name, "_illegal"}, busA.out_illegal, vecs[i].illegal);
      if (vecs[i].chkImm) begin
        checkOutput({vecs[i].name, "_imm"}, busA.out_imm, vecs[i].imm);
        checkOutput({vecs[i].name, "_immz"}, busB.out_imm, vecs[i].immZ);
      end
      @(negedge clk);
      checkOutput({vecs[i].name, "_drain"}, busA.out_valid, 0);
    end

    // Same-cycle write-back bypass into rs, then the stored value.
    @(negedge clk);
    busA.wb_en = 1'b1; busA.wb_addr = 5'd4; busA.wb_data = 32'hAB;
    busA.in_valid = 1'b1; busA.in_instr = rType(5'd4, 5'd0, 5'd1);
    @(negedge clk);
    busA.wb_en = 1'b0; busA.in_valid = 1'b0;
    checkOutput("bypass_op1", busA.out_op1, 32'hAB);
    applyStimulus(rType(5'd0, 5'd4, 5'd1));
    checkOutput("stored_op2", busA.out_op2, 32'hAB);

    // Register 0 ignores writes and the bypass does not fire on address 0.
    writeReg(5'd0, 32'h55);
    applyStimulus(rType(5'd0, 5'd1, 5'd2));
    checkOutput("r0_read", busA.out_op1, 0);
    @(negedge clk);
    busA.wb_en = 1'b1; busA.wb_addr = 5'd0; busA.wb_data = 32'h55;
    busA.in_valid = 1'b1; busA.in_instr = rType(5'd0, 5'd0, 5'd2);
    @(negedge clk);
    busA.wb_en = 1'b0; busA.in_valid = 1'b0;
    checkOutput("r0_bypass", busA.out_op1, 0);

    // Back-to-back: one instruction per cycle.
    @(negedge clk);
    busA.in_valid = 1'b1; busA.in_instr = rType(5'd1, 5'd2, 5'd10);
    @(negedge clk);
    checkOutput("b2b_rd10", busA.out_rd, 10);
    busA.in_instr = rType(5'd1, 5'd2, 5'd11);
    @(negedge clk);
    checkOutput("b2b_rd11", busA.out_rd, 11);
    checkOutput("b2b_valid", busA.out_valid, 1);
    busA.in_instr = rType(5'd1, 5'd2, 5'd12);
    @(negedge clk);
    busA.in_valid = 1'b0;
    checkOutput("b2b_rd12", busA.out_rd, 12);
    @(negedge clk);
    checkOutput("b2b_drain", busA.out_valid, 0);

    // Stall for three cycles with the next instruction waiting; a write-back
    // to rs of the held bundle must not disturb it.
    @(negedge clk);
    busA.out_ready = 1'b0;
    busA.in_valid = 1'b1; busA.in_instr = rType(5'd1, 5'd2, 5'd3);
    @(negedge clk);
    busA.in_instr = {6'd1, 5'd2, 5'd6, 16'h0005};
    busA.wb_en = 1'b1; busA.wb_addr = 5'd1; busA.wb_data = 32'h99;
    for (int c = 0; c < 3; c++) begin
      checkOutput("stall_ready", busA.in_ready, 0);
      checkOutput("stall_valid", busA.out_valid, 1);
      checkOutput("stall_rd", busA.out_rd, 3);
      checkOutput("stall_op1", busA.out_op1, 32'h11);
      @(negedge clk);
      busA.wb_en = 1'b0;
    end
    busA.out_ready = 1'b1;
    @(negedge clk);
    busA.in_valid = 1'b0;
    checkOutput("release_valid", busA.out_valid, 1);
    checkOutput("release_rd", busA.out_rd, 6);
    checkOutput("release_op1", busA.out_op1, 32'h22);
    checkOutput("release_imm", busA.out_imm, 32'h5);
    @(negedge clk);
    checkOutput("release_drain", busA.out_valid, 0);

    // Flush with a held bundle and an incoming one; write-back still lands.
    @(negedge clk);
    busA.out_ready = 1'b0;
    busA.in_valid = 1'b1; busA.in_instr = rType(5'd1, 5'd2, 5'd3);
    @(negedge clk);
    checkOutput("flush_pre", busA.out_valid, 1);
    busA.out_ready = 1'b1; busA.flush = 1'b1;
    busA.in_instr = rType(5'd1, 5'd2, 5'd4);
    busA.wb_en = 1'b1; busA.wb_addr = 5'd9; busA.wb_data = 32'h77;
    @(negedge clk);
    busA.flush = 1'b0; busA.wb_en = 1'b0; busA.in_valid = 1'b0;
    checkOutput("flush_valid", busA.out_valid, 0);
    applyStimulus(rType(5'd9, 5'd1, 5'd2));
    checkOutput("flush_wb", busA.out_op1, 32'h77);
    checkOutput("flush_wb_r1", busA.out_op2, 32'h99);

    // Asynchronous reset in the middle of a stall.
    @(negedge clk);
    busA.out_ready = 1'b0;
    busA.in_valid = 1'b1; busA.in_instr = rType(5'd1, 5'd2, 5'd3);
    @(negedge clk);
    busA.in_valid = 1'b0;
    checkOutput("midrst_pre", busA.out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid", busA.out_valid, 0);
    checkOutput("midrst_rd", busA.out_rd, 0);
    @(negedge clk);
    rst_n = 1'b1;
    busA.out_ready = 1'b1;
    applyStimulus(rType(5'd1, 5'd2, 5'd3));
    checkOutput("midrst_op1", busA.out_op1, 0);
    checkOutput("midrst_op2", busA.out_op2, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end
endmodule
